char_text_buffer: RTL and testbench

- Character-code store for the 16x16-cell text box rendered by the character overlay stage.
- Render side: the overlay stage's registered char_yx/char_line are looked up in a 256x7 buffer. The resulting char_code and char_line_out go to the font ROM, whose char_pixels return to the overlay stage.
- Write side: game logic prints characters through a cursor-based put handshake, can reposition the cursor, and can clear the whole buffer.

---
 rtl/char_text_pkg.sv | 22 ++
 rtl/text_ram_dp.sv | 25 ++
 rtl/char_text_buffer.sv | 103 ++++++++++
 tb/tb_char_text_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_text_pkg.sv
// rtl/char_text_pkg.sv - shared constants, state encoding and cursor helper for the text buffer
package char_text_pkg;

  localparam int TXT_COLS  = 16;
  localparam int TXT_ROWS  = 16;
  localparam int TXT_CELLS = 256;
  localparam int CODE_W    = 7;
  localparam int ADDR_W    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Start of the following row; the 4-bit row field wraps 15 -> 0 on its own.
  function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] a);
    logic [3:0] row;
    row = a[7:4] + 4'd1;
    return {row, 4'h0};
  endfunction

endpackage

// File: rtl/text_ram_dp.sv
// rtl/text_ram_dp.sv - 256x7 simple dual-port character RAM, one write port and one read port
module text_ram_dp
  import char_text_pkg::*;
(
  input  logic              pclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CODE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [TXT_CELLS];

  always_ff @(posedge pclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data is captured by the caller on the same edge as the write, so a
  // same-address collision returns the old contents.
  assign rdata = mem[raddr];

endmodule

// File: rtl/char_text_buffer.sv
// rtl/char_text_buffer.sv - 16x16 character store with cursor-driven put port and clear sweep
module char_text_buffer
  import char_text_pkg::*;
#(
  parameter logic [CODE_W-1:0] FILL_CHAR    = 7'h20,
  parameter logic [CODE_W-1:0] NEWLINE_CODE = 7'h0A
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] char_yx,
  input  logic [3:0]        char_line_in,
  output logic [CODE_W-1:0] char_code,
  output logic [3:0]        char_line_out,
  input  logic              put_valid,
  input  logic [CODE_W-1:0] put_data,
  output logic              put_ready,
  input  logic              cur_set,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CODE_W-1:0] wdata;
  logic [CODE_W-1:0] rd_data;
  logic              put_fire;
  logic              is_nl;

  assign put_ready = (state == ST_IDLE) && !clr_req && !cur_set;
  assign busy      = (state == ST_CLEAR);
  assign put_fire  = put_valid && put_ready;
  assign is_nl     = (put_data == NEWLINE_CODE);

  always_comb begin
    we    = 1'b0;
    waddr = cursor;
    wdata = put_data;
    if (state == ST_CLEAR) begin
      we    = 1'b1;
      waddr = cnt;
      wdata = FILL_CHAR;
    end else if (put_fire && !is_nl) begin
      we = 1'b1;
    end
  end

  text_ram_dp u_ram (
    .pclk  (pclk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (char_yx),
    .rdata (rd_data)
  );

  // Render path is independent of the FSM and never stalls.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      char_code     <= '0;
      char_line_out <= '0;
    end else begin
      char_code     <= rd_data;
      char_line_out <= char_line_in;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state  <= ST_CLEAR;
      cnt    <= '0;
      cursor <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end else if (cur_set) begin
            cursor <= cur_addr;
          end else if (put_valid) begin
            cursor <= is_nl ? next_row(cursor) : cursor + 8'd1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) begin
            state  <= ST_IDLE;
            cursor <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_text_buffer.sv
// tb/tb_char_text_buffer.sv - randomized and directed checks of char_text_buffer against a cell-array model
module tb_char_text_buffer;

  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] char_yx;
  logic [3:0] char_line_in;
  logic [6:0] char_code;
  logic [3:0] char_line_out;
  logic       put_valid;
  logic [6:0] put_data;
  logic       put_ready;
  logic       cur_set;
  logic [7:0] cur_addr;
  logic       clr_req;
  logic       busy;
  logic [7:0] cursor;

  char_text_buffer dut (
    .pclk          (pclk),
    .rst           (rst),
    .char_yx       (char_yx),
    .char_line_in  (char_line_in),
    .char_code     (char_code),
    .char_line_out (char_line_out),
    .put_valid     (put_valid),
    .put_data      (put_data),
    .put_ready     (put_ready),
    .cur_set       (cur_set),
    .cur_addr      (cur_addr),
    .clr_req       (clr_req),
    .busy          (busy),
    .cursor        (cursor)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: cell array (-1 = never written), cycles of clearing left, cursor, expected read outputs.
  int m_mem [256];
  int m_left = 256;
  int m_cur  = 0;
  int m_code = 0;
  int m_line = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = -1;
    forever begin
      @(posedge pclk or posedge rst);
      if (rst) begin
        m_left = 256;
        m_cur  = 0;
        m_code = 0;
        m_line = 0;
      end else begin
        m_code = m_mem[char_yx];
        m_line = char_line_in;
        if (m_left > 0) begin
          m_mem[256 - m_left] = 32;
          m_left--;
          if (m_left == 0) m_cur = 0;
        end else if (clr_req) begin
          m_left = 256;
        end else if (cur_set) begin
          m_cur = cur_addr;
        end else if (put_valid) begin
          if (put_data == 7'h0A) begin
            m_cur = ((m_cur / 16 + 1) % 16) * 16;
          end else begin
            m_mem[m_cur] = put_data;
            m_cur = (m_cur + 1) % 256;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (chk_en) begin
        chk("busy", busy, (m_left > 0) ? 1 : 0);
        chk("put_ready", put_ready, (m_left == 0 && !clr_req && !cur_set) ? 1 : 0);
        chk("cursor", cursor, m_cur);
        chk("char_line_out", char_line_out, m_line);
        if (m_code >= 0) chk("char_code", char_code, m_code);
      end
    end
  end

  task automatic read_cell(input logic [7:0] addr, input int exp);
    logic [3:0] ln;
    ln = 4'($urandom);
    char_yx = addr;
    char_line_in = ln;
    step();
    chk("lit_code", char_code, exp);
    chk("lit_line", char_line_out, ln);
  endtask

  task automatic put(input logic [6:0] d);
    put_valid = 1'b1;
    put_data = d;
    #1;
    chk("lit_put_ready", put_ready, 1);
    step();
    put_valid = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] a);
    cur_set = 1'b1;
    cur_addr = a;
    step();
    cur_set = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(name, n, 256);
  endtask

  initial begin
    rst = 1'b0;
    char_yx = '0;
    char_line_in = '0;
    put_valid = 1'b0;
    put_data = '0;
    cur_set = 1'b0;
    cur_addr = '0;
    clr_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_en = 1'b1;
    chk("rst_code", char_code, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_busy", busy, 1);
    step();
    step();
    rst = 1'b0;
    count_busy("init_busy_len");

    for (int i = 0; i < 256; i++) read_cell(8'(i), 7'h20);

    chk("ab_cursor0", cursor, 0);
    put(7'h41);
    put(7'h42);
    chk("ab_cursor", cursor, 2);
    read_cell(8'h00, 7'h41);
    read_cell(8'h01, 7'h42);

    set_cur(8'hFF);
    put(7'h5A);
    chk("wrap_cursor", cursor, 0);
    read_cell(8'hFF, 7'h5A);
    set_cur(8'hF3);
    put(7'h0A);
    chk("nl_wrap_cursor", cursor, 0);
    read_cell(8'hF3, 7'h20);

    put(7'h31);
    clr_req = 1'b1;
    cur_set = 1'b1;
    cur_addr = 8'h55;
    put_valid = 1'b1;
    put_data = 7'h33;
    #1;
    chk("prio_put_ready", put_ready, 0);
    step();
    clr_req = 1'b0;
    cur_set = 1'b0;
    put_valid = 1'b0;
    chk("prio_busy", busy, 1);
    chk("prio_cursor", cursor, 1);
    count_busy("clr_busy_len");
    chk("clr_cursor", cursor, 0);
    read_cell(8'h00, 7'h20);
    read_cell(8'h01, 7'h20);
    read_cell(8'h55, 7'h20);
    read_cell(8'hFF, 7'h20);

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    put_valid = 1'b1;
    put_data = 7'h47;
    for (int n = 0; n < 400 && busy; n++) begin
      chk("held_put_ready", put_ready, 0);
      step();
    end
    chk("held_busy_done", busy, 0);
    chk("held_accept", put_ready, 1);
    step();
    put_valid = 1'b0;
    chk("held_cursor", cursor, 1);
    read_cell(8'h00, 7'h47);

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_cursor", cursor, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_code", char_code, 0);
    step();
    rst = 1'b0;
    count_busy("restart_busy_len");
    chk("restart_cursor", cursor, 0);

    for (int i = 0; i < 4000; i++) begin
      clr_req = ($urandom_range(0, 299) == 0);
      cur_set = ($urandom_range(0, 19) == 0);
      cur_addr = 8'($urandom);
      put_valid = 1'($urandom);
      put_data = ($urandom_range(0, 7) == 0) ? 7'h0A : 7'($urandom);
      char_yx = 8'($urandom);
      char_line_in = 4'($urandom);
      step();
    end

    clr_req = 1'b0;
    cur_set = 1'b0;
    put_valid = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
